// File: rtl/nibble_serial_addsub_if.sv
// Operand/result handshake between an operand source and the nibble-serial add/sub engine.
// master: drives start/sub/in_a/in_b/cin and samples busy/done/s/cout/ovf.
// slave : the engine side; W must equal 4*NIB of the engine it connects to.
interface nibble_serial_addsub_if #(
   parameter int W = 16
);
   logic         start;
   logic         sub;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] s;
   logic         cout;
   logic         ovf;

   modport master (
      output start, sub, in_a, in_b, cin,
      input  busy, done, s, cout, ovf
   );

   modport slave (
      input  start, sub, in_a, in_b, cin,
      output busy, done, s, cout, ovf
   );
endinterface

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle W-bit add/subtract, one 4-bit carry-lookahead slice per clock, carry chained via a register.
// Latency: start accepted at edge 0, slices at edges 1..NIB, done pulses for the cycle after edge NIB.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted (back-to-back).
// Ports: CLK, reset_n (async active-low), bus (slave modport: start/sub/in_a/in_b/cin in,
//        busy/done/s/cout/ovf out).
module nibble_serial_addsub #(
   parameter int NIB = 4
) (
   input  logic                   CLK,
   input  logic                   reset_n,
   nibble_serial_addsub_if.slave  bus
);
   localparam int W  = 4 * NIB;
   localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, b_q, s_q, s_d;
   logic            carry_q;
   logic [CW-1:0]   cnt_q;
   logic            cout_q, ovf_q;

   logic [3:0]      a_nib, b_nib, g, p, sum_nib;
   logic [4:0]      c;
   logic            accept, last, ovf_d;

   // IDLE and DONE both accept a new operation.
   assign accept = (state_q != RUN) && bus.start;
   assign last   = (cnt_q == LAST);
   assign a_nib  = a_q[4*cnt_q +: 4];
   assign b_nib  = b_q[4*cnt_q +: 4];

   // 4-bit carry-lookahead slice.
   always_comb begin
      g    = a_nib & b_nib;
      p    = a_nib ^ b_nib;
      c[0] = carry_q;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & c[0]);
      sum_nib = p ^ c[3:0];
   end

   // Sum with the current slice merged in; on the last slice its MSB is the final sign.
   always_comb begin
      s_d = s_q;
      s_d[4*cnt_q +: 4] = sum_nib;
   end

   // B is already inverted for subtract, so the usual same-sign overflow rule applies.
   assign ovf_d = (a_q[W-1] == b_q[W-1]) && (s_d[W-1] != a_q[W-1]);

   // State register.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (last)      state_d = DONE;
         DONE:    state_d = bus.start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs.
   always_comb begin
      bus.busy = (state_q == RUN);
      bus.done = (state_q == DONE);
      bus.s    = s_q;
      bus.cout = cout_q;
      bus.ovf  = ovf_q;
   end

   // Datapath: operand latch on accept, one slice per RUN cycle.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         a_q     <= bus.in_a;
         b_q     <= bus.sub ? ~bus.in_b : bus.in_b;
         carry_q <= bus.sub ? ~bus.cin  : bus.cin;
         cnt_q   <= '0;
      end else if (state_q == RUN) begin
         s_q     <= s_d;
         carry_q <= c[4];
         cnt_q   <= cnt_q + CW'(1);
         if (last) begin
            cout_q <= c[4];
            ovf_q  <= ovf_d;
         end
      end
   end
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench for nibble_serial_addsub: expected results queued at launch,
// a negedge monitor pops and compares whenever done is high.
module tb_nibble_serial_addsub;
   localparam int W = 16;

   logic CLK = 1'b0;
   logic reset_n;
   always #5 CLK = ~CLK;

   nibble_serial_addsub_if #(.W(W)) bus_if ();

   nibble_serial_addsub #(.NIB(4)) dut (
      .CLK     (CLK),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   int          tests       = 0;
   int          fails       = 0;
   int          done_pulses = 0;
   logic [17:0] exp_q[$];   // {cout, ovf, s}
   logic [17:0] mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [17:0] enc(input logic [15:0] s, input logic co, input logic ov);
      return {co, ov, s};
   endfunction

   function automatic logic [17:0] model(input logic sb, input logic [15:0] a, input logic [15:0] b,
                                         input logic ci);
      logic [15:0] bb;
      logic        cc;
      logic [16:0] r;
      logic        ov;
      bb = sb ? ~b : b;
      cc = sb ? ~ci : ci;
      r  = {1'b0, a} + {1'b0, bb} + {16'd0, cc};
      ov = (a[15] == bb[15]) && (r[15] != a[15]);
      return {r[16], ov, r[15:0]};
   endfunction

   // Monitor / scoreboard.
   always @(negedge CLK) begin
      if (bus_if.done === 1'b1) begin
         done_pulses++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got s=0x%0h, want no result", bus_if.s);
         end else begin
            mon_e = exp_q.pop_front();
            check("result_s",    {16'd0, bus_if.s},    {16'd0, mon_e[15:0]});
            check("result_cout", {31'd0, bus_if.cout}, {31'd0, mon_e[17]});
            check("result_ovf",  {31'd0, bus_if.ovf},  {31'd0, mon_e[16]});
         end
      end
   end

   // Called #1 after an edge with the engine idle or in its done cycle; returns #1 after edge 0.
   task automatic launch(input logic sb, input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic push, input logic [17:0] exp);
      bus_if.sub   = sb;
      bus_if.in_a  = a;
      bus_if.in_b  = b;
      bus_if.cin   = ci;
      bus_if.start = 1'b1;
      if (push) exp_q.push_back(exp);
      @(posedge CLK); #1;
      bus_if.start = 1'b0;
   endtask

   task automatic wait_done(input string name, output int n);
      n = 0;
      while (n < 20) begin
         @(posedge CLK); #1;
         n++;
         if (bus_if.done === 1'b1) break;
      end
      if (bus_if.done !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got no done after %0d cycles, want done", name, n);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1);
   end

   initial begin
      int n;
      int p;
      logic [15:0] ra, rb;
      logic        rs, rc;

      bus_if.start = 1'b0;
      bus_if.sub   = 1'b0;
      bus_if.in_a  = '0;
      bus_if.in_b  = '0;
      bus_if.cin   = 1'b0;
      reset_n      = 1'b0;

      // 1. Reset state.
      repeat (2) @(posedge CLK);
      #1 reset_n = 1'b1;
      check("rst_busy", {31'd0, bus_if.busy}, 0);
      check("rst_done", {31'd0, bus_if.done}, 0);
      check("rst_s",    {16'd0, bus_if.s},    0);
      check("rst_cout", {31'd0, bus_if.cout}, 0);
      check("rst_ovf",  {31'd0, bus_if.ovf},  0);
      repeat (3) begin @(posedge CLK); #1; end
      check("idle_no_done", done_pulses, 0);

      // 2. Latency and busy profile.
      launch(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b1, enc(16'h5555, 1'b0, 1'b0));
      check("busy_e0", {31'd0, bus_if.busy}, 1);
      for (int i = 1; i <= 3; i++) begin
         @(posedge CLK); #1;
         check("busy_run", {31'd0, bus_if.busy}, 1);
         check("done_early", {31'd0, bus_if.done}, 0);
      end
      @(posedge CLK); #1;
      check("done_e4", {31'd0, bus_if.done}, 1);
      check("busy_e4", {31'd0, bus_if.busy}, 0);
      @(posedge CLK); #1;
      check("done_pulse_len", {31'd0, bus_if.done}, 0);

      // 3. Carry out, then back-to-back start in the done cycle.
      launch(1'b0, 16'hFFFF, 16'h0001, 1'b1, 1'b1, enc(16'h0001, 1'b1, 1'b0));
      wait_done("add_ffff", n);
      check("lat_add_ffff", n, 4);
      launch(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b1, enc(16'h8000, 1'b0, 1'b1));
      wait_done("b2b", n);
      check("lat_b2b", n, 4);
      @(posedge CLK); #1;

      // 4. Subtract with borrow, subtract with overflow.
      launch(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, enc(16'hFFFE, 1'b0, 1'b0));
      wait_done("sub_borrow", n);
      @(posedge CLK); #1;
      launch(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, enc(16'h7FFF, 1'b1, 1'b1));
      wait_done("sub_ovf", n);
      @(posedge CLK); #1;

      // 5. Start while busy is ignored.
      p = done_pulses;
      launch(1'b0, 16'h0F0F, 16'h00F1, 1'b0, 1'b1, enc(16'h1000, 1'b0, 1'b0));
      @(posedge CLK); #1;
      bus_if.start = 1'b1;
      bus_if.sub   = 1'b1;
      bus_if.in_a  = 16'hAAAA;
      bus_if.in_b  = 16'h5555;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      bus_if.start = 1'b0;
      wait_done("ignore_start", n);
      check("lat_ignore_start", n, 1);
      repeat (6) begin @(posedge CLK); #1; end
      check("one_done_pulse", done_pulses - p, 1);

      // 6. Reset mid-operation.
      p = done_pulses;
      launch(1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0, '0);
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      reset_n = 1'b0;
      #1;
      check("abort_s",    {16'd0, bus_if.s},    0);
      check("abort_busy", {31'd0, bus_if.busy}, 0);
      check("abort_done", {31'd0, bus_if.done}, 0);
      check("abort_cout", {31'd0, bus_if.cout}, 0);
      check("abort_ovf",  {31'd0, bus_if.ovf},  0);
      repeat (2) @(posedge CLK);
      #1 reset_n = 1'b1;
      repeat (6) begin @(posedge CLK); #1; end
      check("abort_no_done", done_pulses - p, 0);
      launch(1'b0, 16'h0001, 16'h0001, 1'b0, 1'b1, enc(16'h0002, 1'b0, 1'b0));
      wait_done("after_abort", n);
      @(posedge CLK); #1;

      // 7. Random operations against the whole-word model, mixing idle gaps and back-to-back.
      for (int k = 0; k < 200; k++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rs = 1'($urandom_range(0, 1));
         rc = 1'($urandom_range(0, 1));
         launch(rs, ra, rb, rc, 1'b1, model(rs, ra, rb, rc));
         wait_done("random", n);
         if ($urandom_range(0, 1) == 1) begin
            @(posedge CLK); #1;
         end
      end

      repeat (4) begin @(posedge CLK); #1; end
      check("queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
- Multi-cycle 16-bit add/subtract engine. It is the responder side of the operand/result handshake our arithmetic benches drive.
- Accepts two 16-bit operands plus a carry/borrow on a start strobe.
- Evaluates one 4-bit carry-lookahead slice per clock, chaining the carry through a register, and returns {cout,s} with a one-cycle done pulse.
- Sits between an operand source (bench driver or datapath controller) and any consumer that samples results on done.

Parameters:
- NIB, 4, number of 4-bit slices; total width W = 4*NIB. Default gives 16 bits.

Ports:
- CLK      input   1   clock; all state changes on the rising edge
- reset_n  input   1   asynchronous, active-low reset
- start    input   1   request; sampled only when busy=0
- sub      input   1   0 = add (a+b+cin); 1 = subtract (a-b-cin)
- in_a     input   W   operand A; sampled with start
- in_b     input   W   operand B; sampled with start
- cin      input   1   carry-in (add) or borrow-in (sub); sampled with start
- busy     output  1   high while slices are being evaluated
- done     output  1   one-cycle pulse; result valid
- s        output  W   sum/difference; held until the next accepted start
- cout     output  1   carry out of the MSB slice (for sub: 1 = no borrow)
- ovf      output  1   signed two's-complement overflow

Behaviour:
- Reset (reset_n=0, asynchronous, takes effect immediately):
  - state=IDLE; busy=0, done=0, s=0, cout=0, ovf=0.
  - Internal operand, carry and slice-count registers are cleared.
- States:
  - IDLE: start=1 at an edge -> latch in_a; latch B = sub ? ~in_b : in_b; set carry register = sub ? ~cin : cin; cnt=0; go to RUN; busy=1.
  - RUN: each edge computes slice cnt with a 4-bit CLA:
    - s[4cnt+3:4cnt] = A_nib + B_nib + carry;
    - carry register takes the slice carry-out;
    - cnt++.
    - On the edge that computes slice NIB-1, go to DONE: busy=0, done=1, cout=final carry, ovf=(A[W-1]==B[W-1]) && (s[W-1]!=A[W-1]), where B is the latched (possibly inverted) operand.
  - DONE: lasts one cycle; done returns to 0 at the next edge. start=1 at that edge is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency:
  - The start-accepting edge is edge 0.
  - Slices are evaluated at edges 1..NIB; done is high between edges NIB and NIB+1.
  - Default: done is visible after edge 4. Throughput is one result per NIB+1 cycles.
- start while busy=1 is ignored: no operand re-latch, no effect on the result in flight.
- s updates progressively during RUN (low slices first). Consumers read s only while done=1 or afterwards.
- Between results, s/cout/ovf hold the last completed values.
- Arithmetic: all operations are modulo 2^W. Subtract is a + ~b + ~cin, so cout=0 indicates borrow.
- Reset mid-operation clears everything immediately; no done pulse is produced for the aborted operation.
- Inputs other than start/sub/in_a/in_b/cin are don't-care outside the start-accepting edge.

Test Plan:
1. Hold reset_n=0 for 2 cycles, release -> busy=0, done=0, s=0x0000, cout=0, ovf=0; no done pulse without start.
2. Add 0x1234+0x4321, cin=0 -> done exactly after edge 4 (edge 0 = start) -> s=0x5555, cout=0, ovf=0; busy high after edges 0..3.
3. Add 0xFFFF+0x0001, cin=1 -> s=0x0001, cout=1, ovf=0. Then, in the done cycle, start add 0x7FFF+0x0001, cin=0 -> next done 5 cycles later -> s=0x8000, cout=0, ovf=1.
4. Subtract 0x0005-0x0007, cin=0 -> s=0xFFFE, cout=0 (borrow), ovf=0. Subtract 0x8000-0x0001, cin=0 -> s=0x7FFF, cout=1, ovf=1.
5. Start add 0x0F0F+0x00F1; assert start with 0xAAAA/0x5555 after edges 1 and 2 -> result s=0x1000, cout=0; exactly one done pulse.
6. Start 0x1111+0x2222; drop reset_n after edge 2 -> outputs are 0 at once with no done pulse. After release, add 0x0001+0x0001 -> s=0x0002.
7. Randomized: 200 operations with random in_a, in_b, sub, cin -> {cout,s} and ovf match a reference model each time.
